// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_pkg;

    // Two-state freeze controller: normal flow or waiting on data memory
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    // Execute operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Consecutive MEM_WAIT cycles that count as a stuck memory
    localparam logic [7:0] MEM_TIMEOUT = 8'd255;

    localparam int REG_W = 2;
    localparam int CNT_W = 8;

    // Pick the youngest in-flight producer of src; Memory beats Writeback.
    // Register 0 is deliberately treated as an ordinary register.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] rd_m,
        input logic             wr_m,
        input logic [REG_W-1:0] rd_w,
        input logic             wr_w
    );
        if (wr_m && (rd_m == src))
            return FWD_MEM;
        else if (wr_w && (rd_w == src))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    output logic [DATA_W-1:0] count
);

    // Clear wins over enable; the count sticks at all-ones instead of wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && (count != {DATA_W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: stall/flush control, operand forwarding,
// freeze-cycle statistics and data-memory timeout detection.
module hazard_unit
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic             use_rs_d,
    input  logic             use_rt_d,
    input  logic [REG_W-1:0] rs_e,
    input  logic [REG_W-1:0] rt_e,
    input  logic [REG_W-1:0] rd_e,
    input  logic             reg_write_e,
    input  logic             mem_read_e,
    input  logic [REG_W-1:0] rd_m,
    input  logic             reg_write_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic             reg_write_w,
    input  logic             branch_taken_e,
    input  logic             mem_busy,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_EM,
    output logic             flush_D,
    output logic             flush_E,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_timeout
);

    state_t           state;
    logic             load_use;
    logic             stall_cnt_en;
    logic             wait_cnt_en;
    logic             wait_cnt_clr;
    logic [CNT_W-1:0] wait_count;

    // A load in Execute whose destination is read by the Decode instruction
    assign load_use = mem_read_e && reg_write_e &&
                      ((use_rs_d && (rs_d == rd_e)) || (use_rt_d && (rt_d == rd_e)));

    // Stage enables and flushes; memory freeze > taken branch > load-use bubble
    always_comb begin
        stall_F  = 1'b1;
        stall_D  = 1'b1;
        stall_EM = 1'b1;
        flush_D  = 1'b0;
        flush_E  = 1'b0;
        if (mem_busy) begin
            // Whole pipe frozen; a pending branch flush waits for memory
            stall_F  = 1'b0;
            stall_D  = 1'b0;
            stall_EM = 1'b0;
        end else if (branch_taken_e) begin
            // Wrong-path instructions in D and E are discarded, pipe keeps moving
            flush_D  = 1'b1;
            flush_E  = 1'b1;
        end else if (load_use) begin
            // Hold F/D one cycle and push a bubble into Execute
            stall_F  = 1'b0;
            stall_D  = 1'b0;
            flush_E  = 1'b1;
        end
    end

    // Operand forwarding is pure decode of the current stage contents
    always_comb begin
        fwd_a_e = fwd_sel(rs_e, rd_m, reg_write_m, rd_w, reg_write_w);
        fwd_b_e = fwd_sel(rt_e, rd_m, reg_write_m, rd_w, reg_write_w);
    end

    // Freeze controller: sits in MEM_WAIT for as long as memory reports busy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_RUN;
        else
            case (state)
                ST_RUN:      state <= mem_busy ? ST_MEM_WAIT : ST_RUN;
                ST_MEM_WAIT: state <= mem_busy ? ST_MEM_WAIT : ST_RUN;
                default:     state <= ST_RUN;
            endcase
    end

    assign stall_cnt_en = !stall_D;
    assign wait_cnt_en  = (state == ST_MEM_WAIT);
    assign wait_cnt_clr = !mem_busy;

    sat_counter #(.DATA_W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (1'b0),
        .enable (stall_cnt_en),
        .count  (stall_count)
    );

    // Counts cycles spent in MEM_WAIT; cleared by the edge that returns to RUN
    sat_counter #(.DATA_W(CNT_W)) u_wait_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (wait_cnt_clr),
        .enable (wait_cnt_en),
        .count  (wait_count)
    );

    // Sticky timeout flag; only reset clears it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            mem_timeout <= 1'b0;
        else if (wait_count == MEM_TIMEOUT)
            mem_timeout <= 1'b1;
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// cycles compared against a rule-level reference model.
module tb_hazard_unit;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] rs_d, rt_d, rs_e, rt_e, rd_e, rd_m, rd_w;
    logic       use_rs_d, use_rt_d, reg_write_e, mem_read_e;
    logic       reg_write_m, reg_write_w, branch_taken_e, mem_busy;
    logic       stall_F, stall_D, stall_EM, flush_D, flush_E;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic [7:0] stall_count;
    logic       mem_timeout;

    int checks = 0;
    int failures = 0;

    hazard_unit dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
        .rs_e(rs_e), .rt_e(rt_e),
        .rd_e(rd_e), .reg_write_e(reg_write_e), .mem_read_e(mem_read_e),
        .rd_m(rd_m), .reg_write_m(reg_write_m),
        .rd_w(rd_w), .reg_write_w(reg_write_w),
        .branch_taken_e(branch_taken_e), .mem_busy(mem_busy),
        .stall_F(stall_F), .stall_D(stall_D), .stall_EM(stall_EM),
        .flush_D(flush_D), .flush_E(flush_E),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .stall_count(stall_count), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Reference: expected {stall_F, stall_D, stall_EM, flush_D, flush_E}
    function automatic logic [4:0] model_ctrl(
        input logic busy, input logic br, input logic lr, input logic rw,
        input logic [1:0] rde, input logic urs, input logic [1:0] rsd,
        input logic urt, input logic [1:0] rtd);
        logic hz;
        hz = lr && rw && ((urs && rsd == rde) || (urt && rtd == rde));
        if (busy)    return 5'b000_00;
        else if (br) return 5'b111_11;
        else if (hz) return 5'b001_01;
        else         return 5'b111_00;
    endfunction

    // Reference: forwarding source for one operand
    function automatic logic [1:0] model_fwd(
        input logic [1:0] src, input logic [1:0] rdm, input logic wm,
        input logic [1:0] rdw, input logic ww);
        if (wm && rdm == src)      return 2'b10;
        else if (ww && rdw == src) return 2'b01;
        else                       return 2'b00;
    endfunction

    task automatic set_idle();
        rs_d = 2'd0; rt_d = 2'd0; use_rs_d = 1'b0; use_rt_d = 1'b0;
        rs_e = 2'd0; rt_e = 2'd0; rd_e = 2'd0;
        reg_write_e = 1'b0; mem_read_e = 1'b0;
        rd_m = 2'd0; reg_write_m = 1'b0; rd_w = 2'd0; reg_write_w = 1'b0;
        branch_taken_e = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b0;
        #1;
        checks++;
        if (stall_count !== 8'd0) begin
            failures++; $display("FAIL reset_stall_count got=%0d exp=0", stall_count);
        end
        checks++;
        if (mem_timeout !== 1'b0) begin
            failures++; $display("FAIL reset_mem_timeout got=%0b exp=0", mem_timeout);
        end
        checks++;
        if ({stall_F, stall_D, stall_EM, flush_D, flush_E} !== 5'b111_00) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=11100", {stall_F, stall_D, stall_EM, flush_D, flush_E});
        end
        mem_busy = 1'b1;
        #1;
        checks++;
        if ({stall_F, stall_D, stall_EM, flush_D, flush_E} !== 5'b000_00) begin
            failures++; $display("FAIL reset_busy_freeze got=%b exp=00000", {stall_F, stall_D, stall_EM, flush_D, flush_E});
        end
        @(posedge clk); #1;
        checks++;
        if (stall_count !== 8'd0) begin
            failures++; $display("FAIL reset_hold_count got=%0d exp=0", stall_count);
        end
        @(negedge clk);
        mem_busy = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        rd_e = 2'd2; mem_read_e = 1'b1; reg_write_e = 1'b1;
        rs_d = 2'd2; use_rs_d = 1'b1;
        #1;
        checks++;
        if ({stall_F, stall_D, stall_EM, flush_D, flush_E} !== 5'b001_01) begin
            failures++; $display("FAIL load_use_bubble got=%b exp=00101", {stall_F, stall_D, stall_EM, flush_D, flush_E});
        end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if ({stall_F, stall_D, stall_EM, flush_D, flush_E} !== 5'b111_00) begin
            failures++; $display("FAIL load_use_resume got=%b exp=11100", {stall_F, stall_D, stall_EM, flush_D, flush_E});
        end
        checks++;
        if (stall_count !== 8'd1) begin
            failures++; $display("FAIL load_use_count got=%0d exp=1", stall_count);
        end
    endtask

    task automatic test_branch_over_load();
        do_reset();
        @(negedge clk);
        rd_e = 2'd3; mem_read_e = 1'b1; reg_write_e = 1'b1;
        rt_d = 2'd3; use_rt_d = 1'b1; branch_taken_e = 1'b1;
        #1;
        checks++;
        if ({stall_F, stall_D, stall_EM, flush_D, flush_E} !== 5'b111_11) begin
            failures++; $display("FAIL branch_override got=%b exp=11111", {stall_F, stall_D, stall_EM, flush_D, flush_E});
        end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (stall_count !== 8'd0) begin
            failures++; $display("FAIL branch_count got=%0d exp=0", stall_count);
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        @(negedge clk);
        rs_e = 2'd1; rd_m = 2'd1; reg_write_m = 1'b1; rd_w = 2'd1; reg_write_w = 1'b1;
        #1;
        checks++;
        if (fwd_a_e !== 2'b10) begin
            failures++; $display("FAIL fwd_mem_priority got=%b exp=10", fwd_a_e);
        end
        reg_write_m = 1'b0;
        #1;
        checks++;
        if (fwd_a_e !== 2'b01) begin
            failures++; $display("FAIL fwd_wb got=%b exp=01", fwd_a_e);
        end
        // Register 0 forwarded on operand B while the pipe is frozen
        rt_e = 2'd0; rd_m = 2'd0; reg_write_m = 1'b1; mem_busy = 1'b1;
        #1;
        checks++;
        if (fwd_b_e !== 2'b10) begin
            failures++; $display("FAIL fwd_r0_frozen got=%b exp=10", fwd_b_e);
        end
        checks++;
        if (fwd_a_e !== 2'b01) begin
            failures++; $display("FAIL fwd_a_frozen got=%b exp=01", fwd_a_e);
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_busy_branch();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            branch_taken_e = 1'b1; mem_busy = 1'b1;
            #1;
            checks++;
            if ({stall_F, stall_D, stall_EM, flush_D, flush_E} !== 5'b000_00) begin
                failures++; $display("FAIL busy_branch_freeze%0d got=%b exp=00000", i, {stall_F, stall_D, stall_EM, flush_D, flush_E});
            end
        end
        @(negedge clk);
        mem_busy = 1'b0;
        #1;
        checks++;
        if ({stall_F, stall_D, stall_EM, flush_D, flush_E} !== 5'b111_11) begin
            failures++; $display("FAIL busy_branch_flush got=%b exp=11111", {stall_F, stall_D, stall_EM, flush_D, flush_E});
        end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (stall_count !== 8'd3) begin
            failures++; $display("FAIL busy_branch_count got=%0d exp=3", stall_count);
        end
    endtask

    task automatic test_timeout_and_async_reset();
        do_reset();
        @(negedge clk);
        mem_busy = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        checks++;
        if (mem_timeout !== 1'b0) begin
            failures++; $display("FAIL timeout_early got=%0b exp=0", mem_timeout);
        end
        checks++;
        if (stall_count !== 8'd200) begin
            failures++; $display("FAIL timeout_count200 got=%0d exp=200", stall_count);
        end
        repeat (60) @(posedge clk);
        #1;
        checks++;
        if (mem_timeout !== 1'b1) begin
            failures++; $display("FAIL timeout_set got=%0b exp=1", mem_timeout);
        end
        @(negedge clk);
        mem_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_timeout !== 1'b1) begin
            failures++; $display("FAIL timeout_sticky got=%0b exp=1", mem_timeout);
        end
        checks++;
        if (stall_count !== 8'd255) begin
            failures++; $display("FAIL stall_count_saturate got=%0d exp=255", stall_count);
        end
        checks++;
        if (dut.state !== ST_RUN) begin
            failures++; $display("FAIL timeout_back_to_run got=%0d exp=%0d", dut.state, ST_RUN);
        end
        // Re-enter MEM_WAIT, then pull reset between clock edges
        @(negedge clk);
        mem_busy = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (dut.state !== ST_RUN) begin
            failures++; $display("FAIL async_reset_state got=%0d exp=%0d", dut.state, ST_RUN);
        end
        checks++;
        if (stall_count !== 8'd0 || dut.wait_count !== 8'd0) begin
            failures++; $display("FAIL async_reset_counters got=%0d/%0d exp=0/0", stall_count, dut.wait_count);
        end
        checks++;
        if (mem_timeout !== 1'b0) begin
            failures++; $display("FAIL async_reset_timeout got=%0b exp=0", mem_timeout);
        end
        @(negedge clk);
        set_idle();
        reset = 1'b1;
    endtask

    task automatic test_random();
        int exp_cnt;
        logic [4:0] exp_c;
        logic [1:0] exp_a, exp_b;
        do_reset();
        exp_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rs_d = 2'($urandom); rt_d = 2'($urandom); rs_e = 2'($urandom); rt_e = 2'($urandom);
            rd_e = 2'($urandom); rd_m = 2'($urandom); rd_w = 2'($urandom);
            use_rs_d = 1'($urandom); use_rt_d = 1'($urandom);
            reg_write_e = 1'($urandom); mem_read_e = 1'($urandom);
            reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
            branch_taken_e = ($urandom_range(0, 3) == 0);
            mem_busy = ($urandom_range(0, 9) < 2);
            #1;
            exp_c = model_ctrl(mem_busy, branch_taken_e, mem_read_e, reg_write_e, rd_e,
                               use_rs_d, rs_d, use_rt_d, rt_d);
            exp_a = model_fwd(rs_e, rd_m, reg_write_m, rd_w, reg_write_w);
            exp_b = model_fwd(rt_e, rd_m, reg_write_m, rd_w, reg_write_w);
            checks++;
            if ({stall_F, stall_D, stall_EM, flush_D, flush_E} !== exp_c) begin
                failures++; $display("FAIL rand_ctrl[%0d] got=%b exp=%b", i, {stall_F, stall_D, stall_EM, flush_D, flush_E}, exp_c);
            end
            checks++;
            if ({fwd_a_e, fwd_b_e} !== {exp_a, exp_b}) begin
                failures++; $display("FAIL rand_fwd[%0d] got=%b exp=%b", i, {fwd_a_e, fwd_b_e}, {exp_a, exp_b});
            end
            checks++;
            if (stall_count !== 8'(exp_cnt) || mem_timeout !== 1'b0) begin
                failures++; $display("FAIL rand_count[%0d] got=%0d/%0b exp=%0d/0", i, stall_count, mem_timeout, exp_cnt);
            end
            if (!exp_c[3] && exp_cnt < 255) exp_cnt++;
        end
        @(negedge clk);
        set_idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_over_load();
        test_forwarding();
        test_busy_branch();
        test_timeout_and_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have port clk  input  1  single pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports rs_d, rt_d  input  2 each  source register numbers of the instruction in Decode.
REQ-004 SHALL have ports use_rs_d, use_rt_d  input  1 each  Decode instruction actually reads rs / rt.
REQ-005 SHALL have ports rs_e, rt_e  input  2 each  source register numbers of the instruction in Execute.
REQ-006 SHALL have ports rd_e, reg_write_e, mem_read_e  input  2/1/1  Execute destination, writes-register flag, is-load flag.
REQ-007 SHALL have ports rd_m, reg_write_m  input  2/1  Memory-stage destination and write flag.
REQ-008 SHALL have ports rd_w, reg_write_w  input  2/1  Writeback destination and write flag.
REQ-009 SHALL have port branch_taken_e  input  1  taken branch or jump resolved in Execute.
REQ-010 SHALL have port mem_busy  input  1  data memory not ready this cycle.
REQ-011 SHALL have ports stall_F, stall_D, stall_EM  output  1 each  stage enables; 1 = run, 0 = freeze.
REQ-012 SHALL have ports flush_D, flush_E  output  1 each  1 = clear the IF/ID or ID/EX register to NOP.
REQ-013 SHALL have ports fwd_a_e, fwd_b_e  output  2 each  Execute operand select: 00 register file, 10 from Memory stage, 01 from Writeback.
REQ-014 SHALL have ports stall_count  output  8  saturating count of freeze cycles, and mem_timeout  output  1  sticky error flag.

Function
REQ-015 SHALL implement a registered FSM with states RUN and MEM_WAIT.
REQ-016 RUN->MEM_WAIT SHALL occur on a rising edge where mem_busy=1; MEM_WAIT->RUN SHALL occur on the first edge where mem_busy=0.
REQ-017 Whenever mem_busy=1 (either state), SHALL drive stall_F=stall_D=stall_EM=0, flush_D=flush_E=0; this condition has highest priority.
REQ-018 Load-use hazard = mem_read_e & reg_write_e & ((use_rs_d & rs_d==rd_e) | (use_rt_d & rt_d==rd_e)).
REQ-019 On a load-use hazard with mem_busy=0 and branch_taken_e=0, SHALL drive stall_F=0, stall_D=0, flush_E=1, stall_EM=1 for exactly that cycle, so one bubble is inserted.
REQ-020 On branch_taken_e=1 with mem_busy=0, SHALL drive flush_D=1, flush_E=1, stall_F=stall_D=stall_EM=1 in the same cycle; this overrides load-use.
REQ-021 A branch_taken_e held through MEM_WAIT SHALL produce its flush in the first cycle in which mem_busy=0.
REQ-022 Otherwise SHALL drive all enables=1 and all flushes=0.
REQ-023 fwd_a_e SHALL be 10 if reg_write_m & rd_m==rs_e; else 01 if reg_write_w & rd_w==rs_e; else 00. Memory stage SHALL have priority over Writeback. fwd_b_e SHALL use the same rule with rt_e.
REQ-024 Forwarding outputs SHALL be combinational and SHALL be valid during freezes.
REQ-025 Register 0 SHALL be forwardable like any other register.
REQ-026 stall_count SHALL increment on every edge where stall_D=0, and SHALL saturate at 255 (no wrap).
REQ-027 A wait counter SHALL count consecutive MEM_WAIT cycles. When it reaches MEM_TIMEOUT=255, mem_timeout SHALL set and stay set until reset. The counter SHALL clear on return to RUN.

Reset
REQ-028 While reset=0: state=RUN, stall_count=0, wait counter=0, mem_timeout=0.
REQ-029 During reset, the combinational outputs SHALL follow from RUN with the current inputs; mem_busy still forces a freeze.
REQ-030 Reset asserted mid-MEM_WAIT SHALL return the FSM to RUN immediately (asynchronous), and SHALL clear both counters and mem_timeout.

Structure
REQ-031 Shared package hazard_pkg SHALL hold: state encoding, FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, MEM_TIMEOUT=8'd255.
REQ-032 SHALL instantiate one sub-module, sat_counter (8-bit, enable, synchronous clear, saturating), used for both stall_count and the wait counter.

Verification
REQ-033 Load R2 in E (rd_e=2, mem_read_e=1); D reads rs_d=2 with use_rs_d=1 -> one cycle of stall_F=0, stall_D=0, flush_E=1; next cycle all enables=1; stall_count=1.
REQ-034 branch_taken_e=1 together with a load-use hazard -> flush_D=1, flush_E=1, stall_F=stall_D=1; stall_count unchanged.
REQ-035 rs_e=1 with rd_m=1, reg_write_m=1 and rd_w=1, reg_write_w=1 -> fwd_a_e=10. Then with reg_write_m=0 -> fwd_a_e=01.
REQ-036 mem_busy=1 for 3 cycles while branch_taken_e=1 -> 3 freeze cycles with no flush, then one cycle of flush_D=flush_E=1; stall_count=3.
REQ-037 mem_busy held 260 cycles -> mem_timeout=1 after 255 MEM_WAIT cycles and stays 1 after mem_busy drops; stall_count=255.
REQ-038 reset pulsed low mid-MEM_WAIT -> state=RUN, counters=0, mem_timeout=0 without waiting for a clock edge.
